bitmap_video_fetch: RTL
=======================

// Module: bitmap_video_fetch
// PURPOSE
//  Read side of the bitmap dynamic RAM: fetches 16-bit words (4 pixels x 4 bits) for display, one fetch per 4-pixel group.
//  Applies scroll offsets and screen flip, and requests each word one group ahead over a req/ack port to the DRAM arbiter.
//  Double-buffers each word (prefetch + shifter) and emits one 4-bit colour index per pixel clock enable.
//  Sits between the video timing counters and the colour RAM lookup. Shares DRAM word addressing (DRBA[14:1]) with the CPU write path.
// PARAMETERS
//  FETCH_START  9'd508  hcount at which the first fetch of a line is launched (group 0 preloaded before active video)
//  FETCH_END    9'd252  hcount after which no further fetch is launched on the line (wraps modulo 512)
//  PIX_BITS     4       bits per pixel; word = 4*PIX_BITS
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  pix_ce       in   1   pixel clock enable (one clk pulse per pixel, 5 MHz)
//  hcount       in   9   horizontal pixel counter
//  vcount       in   8   vertical line counter
//  hblank       in   1   horizontal blanking
//  vblank       in   1   vertical blanking
//  scroll_x     in   8   horizontal scroll
//  scroll_y     in   8   vertical scroll
//  flip         in   1   screen flip (cocktail)
//  rd_req       out  1   DRAM read request, held until rd_ack
//  rd_addr      out  14  DRAM word address (DRBA[14:1] equivalent)
//  rd_ack       in   1   one-clk grant pulse; rd_data valid in same cycle
//  rd_data      in   16  DRAM read word
//  pixel        out  4   colour index
//  pixel_valid  out  1   pixel is in active area
//  underrun     out  1   sticky: a group had no data at load time
// BEHAVIOUR
//  Reset: rd_req=0, rd_addr=0, pixel=0, pixel_valid=0, underrun=0, FSM=IDLE, prefetch empty, shifter=0.
//  Coordinates: x=(hcount+4+scroll_x) mod 256, y=(vcount+scroll_y) mod 256; flip: x=255-x, y=255-y. 8-bit wrap, no carry out.
//  rd_addr={y[7:0], x[7:2]}. Fetch targets the group displayed 4 pixels later.
//  FSM: IDLE -> REQ on pix_ce with hcount[1:0]==0 inside the fetch window. Address is latched in the same cycle.
//   REQ: rd_req=1 and rd_addr stable until rd_ack. On rd_ack: capture rd_data into prefetch, mark it full, go to IDLE (rd_req=0 next clk).
//   A launch condition arriving while in REQ is dropped (no queueing).
//  Load: on pix_ce with hcount[1:0]==0: if prefetch full, shifter<=prefetch and prefetch marked empty.
//   If prefetch is empty and rd_ack is in the same cycle: bypass rd_data into the shifter, no underrun.
//   If prefetch is empty with no rd_ack: shifter<=0 and underrun<=1 when not in blanking.
//  Shift order: non-flip emits nibble [3:0] first, then [7:4],[11:8],[15:12]. Flip emits [15:12] first.
//  Output: pixel/pixel_valid are registered on pix_ce. Latency is 1 pix_ce from the shifter nibble. pixel=0 when blanking.
//   pixel_valid=~hblank&~vblank, delayed to align with pixel.
//  rd_ack when rd_req=0 is ignored.
//  underrun clears on the rising edge of vblank.
//  Reset asserted mid-request drops rd_req asynchronously. No ack is expected afterwards.
//  scroll/flip are sampled at each launch only. Mid-line changes take effect on the next group.
// STRUCTURE
//  cc_video_pkg: screen width/height, PIX_BITS, word width, FSM state enum, nibble-order constants.
//  One sub-module: bitmap_pixel_shifter. It owns the 16-bit shifter, flip-dependent nibble select and output registers.
//   The top level owns the address generator, FSM and prefetch buffer.
// TESTING
//  1. scroll=0, flip=0, line vcount=5, ack 2 clk after req -> rd_addr sequence {8'd5,6'd0},{8'd5,6'd1}...; word 16'h4321 -> pixels 1,2,3,4.
//  2. flip=1, same setup -> first rd_addr={8'd250,6'd63}; word 16'h4321 -> pixels 4,3,2,1.
//  3. scroll_x=8'hFE, hcount=0 -> x wraps to 2 -> rd_addr[5:0]=0; scroll_y=8'hFF, vcount=1 -> y=0.
//  4. Withhold rd_ack past the load point -> pixels 0 in active area, underrun=1. It stays set until the vblank rise, then clears.
//  5. rd_ack in the same clk as the load with prefetch empty -> bypass data displayed, underrun stays 0.
//  6. reset_n low while rd_req=1 -> rd_req,pixel,pixel_valid=0 immediately; after release, first fetch is at next window start.

Source files
------------

// File: rtl/cc_video_pkg.sv
// Shared video constants, fetch FSM states and nibble helpers
// for the bitmap DRAM read path.
package cc_video_pkg;

  localparam int SCREEN_W = 256;
  localparam int SCREEN_H = 256;
  localparam int PIX_BITS = 4;
  localparam int WORD_W   = 4 * PIX_BITS;

  localparam logic [8:0] FETCH_START = 9'd508;
  localparam logic [8:0] FETCH_END   = 9'd252;

  localparam logic [1:0] NIB_FIRST = 2'd0;
  localparam logic [1:0] NIB_LAST  = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } fetch_state_e;

  function automatic logic [PIX_BITS-1:0] nib_sel(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        i
  );
    return w[i*PIX_BITS +: PIX_BITS];
  endfunction

endpackage

// File: rtl/bitmap_pixel_shifter.sv
// Holds the displayed word, walks its nibbles in flip order
// and registers the colour index with its valid flag.
module bitmap_pixel_shifter
  import cc_video_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic        load,
  input  logic [15:0] load_word,
  input  logic        load_flip,
  input  logic        vis,
  output logic [3:0]  pixel,
  output logic        pixel_valid
);

  logic [15:0] sh_q;
  logic [1:0]  cnt_q;
  logic        fl_q;
  logic        vis_q;
  logic [1:0]  sel;

  assign sel = fl_q ? (NIB_LAST - cnt_q) : (NIB_FIRST + cnt_q);

  // word holder and nibble position, flip captured with the word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      fl_q  <= 1'b0;
    end else if (pix_ce) begin
      if (load) begin
        sh_q  <= load_word;
        cnt_q <= '0;
        fl_q  <= load_flip;
      end else begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // output stage; visibility delayed one pixel to line up with data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vis_q       <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
    end else if (pix_ce) begin
      vis_q       <= vis;
      pixel       <= vis_q ? nib_sel(sh_q, sel) : 4'd0;
      pixel_valid <= vis_q;
    end
  end

endmodule

// File: rtl/bitmap_video_fetch.sv
// Bitmap DRAM read side: address generation, one-ahead fetch
// FSM, prefetch buffer and underrun tracking.
module bitmap_video_fetch
  import cc_video_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic [8:0]  hcount,
  input  logic [7:0]  vcount,
  input  logic        hblank,
  input  logic        vblank,
  input  logic [7:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  input  logic        flip,
  output logic        rd_req,
  output logic [13:0] rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic [3:0]  pixel,
  output logic        pixel_valid,
  output logic        underrun
);

  fetch_state_e state_q, state_d;

  logic        armed_q;
  logic        req_flip_q;
  logic        pf_full_q;
  logic [15:0] pf_data_q;
  logic        pf_flip_q;
  logic        vblank_q;

  logic        grp_pt, in_win, win_start;
  logic        launch, ack_v, bypass, vis;
  logic [7:0]  x_raw, y_raw, x, y;
  logic [15:0] ld_word;
  logic        ld_flip;

  assign grp_pt    = pix_ce & (hcount[1:0] == 2'b00);
  assign in_win    = (hcount >= FETCH_START) | (hcount <= FETCH_END);
  assign win_start = hcount == FETCH_START;
  assign launch    = grp_pt & in_win & (armed_q | win_start);
  assign ack_v     = rd_ack & (state_q == ST_REQ);
  assign bypass    = grp_pt & ~pf_full_q & ack_v;
  assign vis       = ~hblank & ~vblank;
  assign rd_req    = state_q == ST_REQ;

  assign x_raw = hcount[7:0] + 8'd4 + scroll_x;
  assign y_raw = vcount + scroll_y;
  assign x     = flip ? ~x_raw : x_raw;
  assign y     = flip ? ~y_raw : y_raw;

  // next-state: launch only from idle, ack returns to idle
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == ST_IDLE: if (launch) state_d = ST_REQ;
      state_q == ST_REQ:  if (rd_ack) state_d = ST_IDLE;
    endcase
  end

  // word handed to the shifter at a group boundary
  always_comb begin
    ld_word = '0;
    ld_flip = 1'b0;
    if (pf_full_q) begin
      ld_word = pf_data_q;
      ld_flip = pf_flip_q;
    end else if (ack_v) begin
      ld_word = rd_data;
      ld_flip = req_flip_q;
    end
  end

  // state, request address and post-reset arming
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rd_addr    <= '0;
      req_flip_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch && state_q == ST_IDLE) begin
        rd_addr    <= {y, x[7:2]};
        req_flip_q <= flip;
      end
      if (grp_pt && win_start)
        armed_q <= 1'b1;
    end
  end

  // prefetch buffer: drained at load, filled on a non-bypass ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf_full_q <= 1'b0;
      pf_data_q <= '0;
      pf_flip_q <= 1'b0;
    end else begin
      if (grp_pt && pf_full_q)
        pf_full_q <= 1'b0;
      if (ack_v && !bypass) begin
        pf_full_q <= 1'b1;
        pf_data_q <= rd_data;
        pf_flip_q <= req_flip_q;
      end
    end
  end

  // sticky underrun, cleared when vertical blank begins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q <= 1'b0;
      underrun <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (vblank && !vblank_q)
        underrun <= 1'b0;
      else if (grp_pt && !pf_full_q && !ack_v && vis)
        underrun <= 1'b1;
    end
  end

  bitmap_pixel_shifter u_shifter (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .load        (grp_pt),
    .load_word   (ld_word),
    .load_flip   (ld_flip),
    .vis         (vis),
    .pixel       (pixel),
    .pixel_valid (pixel_valid)
  );

endmodule
